multimode_divider: RTL and testbench

Parametrised sequential radix-2 restoring divider, successor to the fixed unsigned divider. It adds a per-operation signed/unsigned mode, an accept handshake that supports back-to-back operations, and single-cycle fast paths for divide-by-zero and signed overflow, each with its own status flag. It sits behind the ALU issue logic as a multi-cycle functional unit: one operation is in flight at a time, and results are held until the next completion.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 21 ++
 rtl/multimode_divider.sv | 117 +++++++++++
 tb/tb_multimode_divider.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multimode divider: FSM encoding, fast-path constants
// and the counter sizing helper.
package div_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int MAX_N = 64;
  // Divide-by-zero quotient; users slice the low N bits.
  localparam logic [MAX_N-1:0] DBZ_QUOT = '1;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract,
// keep the difference only when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   prem,
  input  logic         din,
  input  logic [N-1:0] dmag,
  output logic [N:0]   prem_nx,
  output logic         q_bit
);
  // One extra bit so the borrow of the trial subtract is visible.
  logic [N+1:0] sh, diff;

  assign sh      = {prem, din};
  assign diff    = sh - {2'b00, dmag};
  assign q_bit   = ~diff[N+1];
  assign prem_nx = q_bit ? diff[N:0] : sh[N:0];
endmodule

// File: rtl/multimode_divider.sv
// Sequential radix-2 restoring divider with signed/unsigned mode, back-to-back accept
// and single-cycle divide-by-zero / signed-overflow fast paths.
module multimode_divider
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         valid,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         in_ready,
  output logic         ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);
  localparam int CW = cnt_w(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N:0]    rem, rem_nx;
  logic [N-1:0]  dq, dmag;
  logic          q_neg, r_neg, dz_l, ov_l, q_bit;

  logic          dz_in, ov_in;
  logic [N-1:0]  a_mag, b_mag, q_raw, q_fix, r_fix;

  assign dz_in = (divisor == '0);
  assign ov_in = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
  assign a_mag = (is_signed && dividend[N-1]) ? -dividend : dividend;
  assign b_mag = (is_signed && divisor[N-1])  ? -divisor  : divisor;

  assign in_ready = (state != S_CALC);

  // dq doubles as the dividend shifter and the quotient accumulator.
  div_step #(.N(N)) u_step (
    .prem    (rem),
    .din     (dq[N-1]),
    .dmag    (dmag),
    .prem_nx (rem_nx),
    .q_bit   (q_bit)
  );

  assign q_raw = {dq[N-2:0], q_bit};
  assign q_fix = q_neg ? -q_raw : q_raw;
  assign r_fix = r_neg ? -rem_nx[N-1:0] : rem_nx[N-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem         <= '0;
      dq          <= '0;
      dmag        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz_l        <= 1'b0;
      ov_l        <= 1'b0;
      ready       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (valid) begin
            state <= S_CALC;
            dz_l  <= dz_in;
            ov_l  <= ov_in;
            rem   <= '0;
            if (dz_in || ov_in) begin
              // Fast path keeps the raw dividend for the result.
              cnt <= CW'(1);
              dq  <= dividend;
            end else begin
              cnt   <= CW'(N);
              dq    <= a_mag;
              dmag  <= b_mag;
              q_neg <= is_signed & (dividend[N-1] ^ divisor[N-1]);
              r_neg <= is_signed & dividend[N-1];
            end
          end
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (dz_l || ov_l) begin
            state       <= S_DONE;
            ready       <= 1'b1;
            quotient    <= dz_l ? DBZ_QUOT[N-1:0] : dq;
            remainder   <= dz_l ? dq : '0;
            div_by_zero <= dz_l;
            overflow    <= ov_l;
          end else begin
            rem <= rem_nx;
            dq  <= q_raw;
            if (cnt == CW'(1)) begin
              state       <= S_DONE;
              ready       <= 1'b1;
              quotient    <= q_fix;
              remainder   <= r_fix;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multimode_divider.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks
// and a randomized phase, all for N=8.
module tb_multimode_divider;
  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         valid;
  logic         is_signed;
  logic [N-1:0] dividend, divisor;
  logic         in_ready, ready, div_by_zero, overflow;
  logic [N-1:0] quotient, remainder;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  multimode_divider #(.N(N)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .valid       (valid),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .in_ready    (in_ready),
    .ready       (ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  function automatic res_t ref_div(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
    res_t t;
    int   sa, sb;
    t = '0;
    if (b == 0) begin
      t.q  = '1;
      t.r  = a;
      t.dz = 1'b1;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      t.q  = a;
      t.ov = 1'b1;
    end else if (s) begin
      sa  = $signed(a);
      sb  = $signed(b);
      t.q = N'(sa / sb);
      t.r = N'(sa % sb);
    end else begin
      t.q = a / b;
      t.r = a % b;
    end
    return t;
  endfunction

  function automatic int ref_lat(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == 0 || (s && a == 8'h80 && b == 8'hFF)) ? 1 : N;
  endfunction

  // Model: edges remaining until completion (0 = can accept), pending and visible results.
  int   m_cnt;
  bit   m_rdy;
  res_t m_res, p_res;

  always @(posedge CLK) begin
    if (RST) begin
      m_cnt <= 0;
      m_rdy <= 1'b0;
      m_res <= '0;
    end else begin
      m_rdy <= 1'b0;
      if (m_cnt == 1) begin
        m_rdy <= 1'b1;
        m_res <= p_res;
      end
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else if (valid) begin
        p_res <= ref_div(is_signed, dividend, divisor);
        m_cnt <= ref_lat(is_signed, dividend, divisor);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_ready",    32'(ready),       32'(m_rdy));
      chk("m_in_ready", 32'(in_ready),    32'(m_cnt == 0));
      chk("m_quot",     32'(quotient),    32'(m_res.q));
      chk("m_rem",      32'(remainder),   32'(m_res.r));
      chk("m_dz",       32'(div_by_zero), 32'(m_res.dz));
      chk("m_ov",       32'(overflow),    32'(m_res.ov));
    end
  end

  function automatic logic [N-1:0] pick();
    case ($urandom % 6)
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'hFF;
      default: return N'($urandom);
    endcase
  endfunction

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end while (!ready && lat < 40);
  endtask

  task automatic do_op(input string nm, input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input bit edz, input bit eov,
                       input int elat);
    int lat;
    @(negedge CLK);
    valid = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge CLK);
    #1;
    valid = 1'b0; dividend = N'($urandom); divisor = N'($urandom); is_signed = ~s;
    wait_ready(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_q"},   32'(quotient),    32'(eq));
    chk({nm, "_r"},   32'(remainder),   32'(er));
    chk({nm, "_dz"},  32'(div_by_zero), 32'(edz));
    chk({nm, "_ov"},  32'(overflow),    32'(eov));
    @(negedge CLK);
    chk({nm, "_pulse"}, 32'(ready), 32'(0));
  endtask

  initial begin
    int lat, lat2, seen;
    RST = 1'b1; valid = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready",    32'(ready),       32'(0));
    chk("rst_in_ready", 32'(in_ready),    32'(1));
    chk("rst_q",        32'(quotient),    32'(0));
    chk("rst_r",        32'(remainder),   32'(0));
    chk("rst_flags",    32'({div_by_zero, overflow}), 32'(0));
    chk_en = 1'b1;
    RST = 1'b0;

    do_op("u14_3",  1'b0, 8'd14, 8'd3,  8'd4,  8'd2,  1'b0, 1'b0, N);
    do_op("s_m7_2", 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, N);
    do_op("s_5_m3", 1'b1, 8'h05, 8'hFD, 8'hFF, 8'h02, 1'b0, 1'b0, N);
    do_op("dz_u",   1'b0, 8'd17, 8'd0,  8'hFF, 8'h11, 1'b1, 1'b0, 1);
    do_op("dz_s",   1'b1, 8'd17, 8'd0,  8'hFF, 8'h11, 1'b1, 1'b0, 1);
    do_op("ovf",    1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1);
    do_op("u80_ff", 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, N);

    // Back-to-back with valid held high; operands switched during CALC.
    @(negedge CLK);
    valid = 1'b1; is_signed = 1'b0; dividend = 8'd255; divisor = 8'd1;
    @(posedge CLK);
    #1;
    dividend = 8'd200; divisor = 8'd7;
    wait_ready(lat);
    chk("b2b1_lat", 32'(lat), 32'(N));
    chk("b2b1_q",   32'(quotient),  32'(255));
    chk("b2b1_r",   32'(remainder), 32'(0));
    wait_ready(lat2);
    chk("b2b2_gap", 32'(lat2), 32'(N + 1));
    chk("b2b2_q",   32'(quotient),  32'(28));
    chk("b2b2_r",   32'(remainder), 32'(4));
    valid = 1'b0;
    @(negedge CLK);

    // Reset abort at A+4.
    @(negedge CLK);
    valid = 1'b1; is_signed = 1'b0; dividend = 8'd100; divisor = 8'd9;
    @(posedge CLK);
    #1;
    valid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_ready",    32'(ready),       32'(0));
    chk("abort_in_ready", 32'(in_ready),    32'(1));
    chk("abort_q",        32'(quotient),    32'(0));
    chk("abort_r",        32'(remainder),   32'(0));
    chk("abort_flags",    32'({div_by_zero, overflow}), 32'(0));
    RST = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge CLK);
      if (ready) seen++;
    end
    chk("abort_no_pulse", 32'(seen), 32'(0));
    do_op("u100_9", 1'b0, 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b0, N);

    // Randomized traffic, rare resets, operands biased to corner values.
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      RST       = ($urandom % 150) == 0;
      valid     = ($urandom % 3) != 0;
      is_signed = 1'($urandom);
      dividend  = pick();
      divisor   = pick();
    end
    @(negedge CLK);
    RST = 1'b0; valid = 1'b0;
    repeat (12) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
